// File: rtl/uart_pkg.sv
// Shared constants and types for the UART frame receiver: header default,
// FSM state encoding and error codes.
package uart_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_CHECKSUM = 2'b01,
        ERR_LENGTH   = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_t;

    // Address width for a memory of the given depth (at least one bit).
    function automatic int unsigned buf_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: Depth x 8 memory with one write port and
// one registered read port.
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = buf_addr_width(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [7:0]       rd_data_o
);

    logic [7:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder for Header/LEN/payload/CHK byte streams; buffers the payload
// and releases it on a valid/ready stream only after the checksum matches.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int unsigned MaxLen        = 16,
    parameter int unsigned TimeoutCycles = 1_000_000,
    parameter logic [7:0]  Header        = HEADER_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_tick_i,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    output logic       out_last_o,
    output logic       frame_ok_tick_o,
    output logic       frame_err_tick_o,
    output logic [1:0] err_code_o,
    output logic       overrun_tick_o
);

    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    localparam int unsigned IW = $clog2(MaxLen + 1);
    localparam int unsigned AW = buf_addr_width(MaxLen);
    localparam logic [TW-1:0] TmoLast = TW'(TimeoutCycles - 1);

    state_t        state, state_d;
    logic [IW-1:0] len, len_m1, idx, fetch;
    logic [7:0]    sum;
    logic [TW-1:0] tmo_cnt;
    logic          active, timeout_hit, len_bad, chk_match;
    logic          ok_set, err_set, buf_we, load, hs_last;
    err_t          err_val, err_code;
    logic          valid_q, last_q, ok_tick_q, err_tick_q;
    logic [7:0]    rd_data;

    assign active      = state inside {ST_LEN, ST_PAYLOAD, ST_CHK};
    assign timeout_hit = active && !rx_done_tick_i && (tmo_cnt == TmoLast);
    assign len_bad     = (rx_data_i == '0) || (32'(rx_data_i) > MaxLen);
    assign chk_match   = (rx_data_i == sum);
    assign len_m1      = len - IW'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (rx_done_tick_i && rx_data_i == Header) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (rx_done_tick_i) state_d = len_bad ? ST_IDLE : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (rx_done_tick_i && idx == len_m1) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (rx_done_tick_i) state_d = chk_match ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (hs_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) state_d = ST_IDLE;
    end

    always_comb begin
        ok_set  = 1'b0;
        err_set = 1'b0;
        err_val = ERR_NONE;
        buf_we  = 1'b0;
        load    = 1'b0;
        hs_last = 1'b0;
        case (state)
            ST_LEN: begin
                if (rx_done_tick_i && len_bad) begin
                    err_set = 1'b1;
                    err_val = ERR_LENGTH;
                end
            end
            ST_PAYLOAD: buf_we = rx_done_tick_i;
            ST_CHK: begin
                if (rx_done_tick_i) begin
                    ok_set  = chk_match;
                    err_set = !chk_match;
                    err_val = ERR_CHECKSUM;
                end
            end
            ST_DRAIN: begin
                // Prefetch the next byte whenever the output slot is empty or being consumed.
                load    = (fetch != len) && (!valid_q || out_ready_i);
                hs_last = valid_q && out_ready_i && last_q;
            end
            default: ;
        endcase
        if (timeout_hit) begin
            err_set = 1'b1;
            err_val = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            len        <= '0;
            idx        <= '0;
            fetch      <= '0;
            sum        <= '0;
            tmo_cnt    <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            ok_tick_q  <= 1'b0;
            err_tick_q <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            ok_tick_q  <= ok_set;
            err_tick_q <= err_set;
            if (err_set) begin
                err_code <= err_val;
            end else if (ok_set) begin
                err_code <= ERR_NONE;
            end

            if (!active || rx_done_tick_i || timeout_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (state == ST_LEN && rx_done_tick_i) begin
                len <= IW'(rx_data_i);
                sum <= rx_data_i;
                idx <= '0;
            end
            if (buf_we) begin
                sum <= sum + rx_data_i;
                idx <= idx + IW'(1);
            end

            if (ok_set) begin
                fetch <= '0;
            end else if (load) begin
                fetch <= fetch + IW'(1);
            end

            if (load) begin
                valid_q <= 1'b1;
                last_q  <= (fetch == len_m1);
            end else if (valid_q && out_ready_i) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    uart_frame_buf #(
        .Depth (MaxLen),
        .AddrW (AW)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (buf_we),
        .wr_addr_i (idx[AW-1:0]),
        .wr_data_i (rx_data_i),
        .rd_en_i   (load),
        .rd_addr_i (fetch[AW-1:0]),
        .rd_data_o (rd_data)
    );

    assign out_data_o       = rd_data;
    assign out_valid_o      = valid_q;
    assign out_last_o       = last_q;
    assign frame_ok_tick_o  = ok_tick_q;
    assign frame_err_tick_o = err_tick_q;
    assign err_code_o       = err_code;
    assign overrun_tick_o   = (state == ST_DRAIN) && rx_done_tick_i;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: good, bad-checksum, bad-length, timeout,
// overrun/back-pressure and mid-frame reset frames.
module tb_uart_frame_rx;

    localparam int unsigned TMO = 40;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_tick = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_last, ok_tick, err_tick, overrun;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, both_cnt = 0, valid_cnt = 0;
    int ok_cyc = 0, err_cyc = 0, strobe_cyc = 0;
    logic [7:0] got_data[$];
    logic       got_last[$];
    int         got_cyc[$];

    uart_frame_rx #(
        .MaxLen        (16),
        .TimeoutCycles (TMO),
        .Header        (8'hA5)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .rx_data_i        (rx_data),
        .rx_done_tick_i   (rx_tick),
        .out_ready_i      (ready),
        .out_data_o       (out_data),
        .out_valid_o      (out_valid),
        .out_last_o       (out_last),
        .frame_ok_tick_o  (ok_tick),
        .frame_err_tick_o (err_tick),
        .err_code_o       (err_code),
        .overrun_tick_o   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observations are taken on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        if (ok_tick) begin ok_cnt++; ok_cyc = cyc; end
        if (err_tick) begin err_cnt++; err_cyc = cyc; end
        if (ok_tick && err_tick) both_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_tick) strobe_cyc = cyc;
        if (out_valid) valid_cnt++;
        if (out_valid && ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_tick = 1'b0;
    endtask

    task automatic send_seq(input byte_q_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_data"}, 32'(out_data), 32'h0);
        check_eq({tag, "_ctl"}, {27'b0, out_valid, out_last, ok_tick, err_tick, overrun}, 32'h0);
        check_eq({tag, "_code"}, 32'(err_code), 32'h0);
    endtask

    initial begin
        byte_q_t fq;
        int ok0, err0, ovr0, v0, n0;

        // Reset state
        idle(2);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Good frame, consumer always ready
        ready = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt; n0 = got_data.size();
        fq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq(fq);
        idle(8);
        check_eq("good_ok", 32'(ok_cnt - ok0), 32'd1);
        check_eq("good_err", 32'(err_cnt - err0), 32'd0);
        check_eq("good_n", 32'(got_data.size() - n0), 32'd3);
        if (got_data.size() - n0 == 3) begin
            check_eq("good_b0", 32'(got_data[n0]), 32'h11);
            check_eq("good_b1", 32'(got_data[n0+1]), 32'h22);
            check_eq("good_b2", 32'(got_data[n0+2]), 32'h33);
            check_eq("good_last", {29'b0, got_last[n0], got_last[n0+1], got_last[n0+2]}, 32'b001);
            check_eq("good_first_lat", 32'(got_cyc[n0] - ok_cyc), 32'd1);
            check_eq("good_rate", 32'(got_cyc[n0+2] - got_cyc[n0]), 32'd2);
        end
        check_eq("good_code", 32'(err_code), 32'h0);

        // Checksum mismatch: 02+10+20 = 32, sent 00
        err0 = err_cnt; v0 = valid_cnt;
        fq = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_seq(fq);
        idle(6);
        check_eq("chk_err", 32'(err_cnt - err0), 32'd1);
        check_eq("chk_code", 32'(err_code), 32'h1);
        check_eq("chk_novalid", 32'(valid_cnt - v0), 32'd0);

        // Length zero and length above MaxLen
        err0 = err_cnt;
        fq = {8'hA5, 8'h00};
        send_seq(fq);
        idle(3);
        check_eq("len0_err", 32'(err_cnt - err0), 32'd1);
        check_eq("len0_code", 32'(err_code), 32'h2);
        fq = {8'hA5, 8'h11};
        send_seq(fq);
        idle(3);
        check_eq("len17_err", 32'(err_cnt - err0), 32'd2);
        check_eq("len17_code", 32'(err_code), 32'h2);

        // Inter-byte timeout, then a frame whose checksum wraps to 00
        err0 = err_cnt; ok0 = ok_cnt; n0 = got_data.size();
        fq = {8'hA5, 8'h02, 8'h10};
        send_seq(fq);
        idle(TMO + 20);
        check_eq("tmo_err", 32'(err_cnt - err0), 32'd1);
        check_eq("tmo_code", 32'(err_code), 32'h3);
        check_eq("tmo_delay", 32'(err_cyc - strobe_cyc), 32'(TMO + 1));
        fq = {8'hA5, 8'h01, 8'hFF, 8'h00};
        send_seq(fq);
        idle(5);
        check_eq("wrap_ok", 32'(ok_cnt - ok0), 32'd1);
        check_eq("wrap_n", 32'(got_data.size() - n0), 32'd1);
        if (got_data.size() - n0 == 1) begin
            check_eq("wrap_b0", {23'b0, got_last[n0], got_data[n0]}, {23'b0, 1'b1, 8'hFF});
        end

        // Back-pressure with an overrun byte during DRAIN; 02+AA+BB = 167 -> 67
        ready = 1'b0;
        ok0 = ok_cnt; ovr0 = ovr_cnt; n0 = got_data.size();
        fq = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
        send_seq(fq);
        idle(3);
        check_eq("bp_ok", 32'(ok_cnt - ok0), 32'd1);
        check_eq("bp_hold0", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'hAA});
        send_byte(8'h55);
        check_eq("bp_overrun", 32'(ovr_cnt - ovr0), 32'd1);
        idle(14);
        check_eq("bp_hold1", {22'b0, out_valid, out_last, out_data}, {22'b0, 2'b10, 8'hAA});
        ready = 1'b1;
        idle(5);
        check_eq("bp_n", 32'(got_data.size() - n0), 32'd2);
        if (got_data.size() - n0 == 2) begin
            check_eq("bp_b0", {23'b0, got_last[n0], got_data[n0]}, {23'b0, 1'b0, 8'hAA});
            check_eq("bp_b1", {23'b0, got_last[n0+1], got_data[n0+1]}, {23'b0, 1'b1, 8'hBB});
        end

        // Reset in the middle of PAYLOAD
        ok0 = ok_cnt; err0 = err_cnt; n0 = got_data.size();
        fq = {8'hA5, 8'h03, 8'h01};
        send_seq(fq);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        idle(2);
        rst_n = 1'b1;
        idle(TMO + 5);
        check_eq("midrst_ticks", 32'((ok_cnt - ok0) + (err_cnt - err0)), 32'd0);
        fq = {8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_seq(fq);
        idle(5);
        check_eq("post_ok", 32'(ok_cnt - ok0), 32'd1);
        check_eq("post_n", 32'(got_data.size() - n0), 32'd1);
        if (got_data.size() - n0 == 1) begin
            check_eq("post_b0", {23'b0, got_last[n0], got_data[n0]}, {23'b0, 1'b1, 8'h7E});
        end

        check_eq("ok_err_exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
